alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the CPU datapath ALU.
- Single-cycle logic, arithmetic and compare ops, plus iterative signed/unsigned multiply and divide into internal HI/LO registers.
- MFHI/MFLO and MTHI/MTLO access those registers.
- Sits in the execute stage. The pipeline stalls on in_ready low while a multiply or divide is in flight.

Parameters:
- n, 32, operand/result width in bits (n ≥ 4, even).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request this cycle
- op  input  4  operation code (see Behaviour)
- a  input  n  operand A (rs)
- b  input  n  operand B (rt/immediate)
- out_valid  output  1  one-cycle pulse: result/zero/div_by_zero are new
- result  output  n  registered result, held between pulses
- zero  output  1  registered (result == 0), updated with result
- div_by_zero  output  1  registered, set with out_valid of a DIV/DIVU whose b==0, else cleared at each out_valid

Behaviour:
- Accept occurs when in_valid && in_ready at a rising edge.
- op encoding:
  - 0000 AND, 0001 OR, 0010 NOR, 0011 ADD, 0100 SUB
  - 0101 MFHI, 0110 MFLO, 0111 SLT (signed), 1000 SLTU, 1101 XOR
  - 1001 MULT (signed), 1010 MULTU, 1011 DIV (signed), 1100 DIVU
  - 1110 MTHI (HI<=a), 1111 MTLO (LO<=a)
- ADD/SUB wrap modulo 2^n; no overflow trap. SLT/SLTU give 1 or 0, zero-extended.
- Single-cycle ops (all except 1001–1100): result, zero and out_valid are registered at the accept edge, so out_valid is high the following cycle. in_ready stays high, and back-to-back accepts give one result per cycle.
- MTHI/MTLO: write HI/LO at the accept edge, pulse out_valid, and set result = a.
- FSM states IDLE, RUN, FIX, DONE:
  - IDLE: in_ready=1. A mul/div accept latches operand magnitudes, the sign flags and the op, clears the counter, and moves to RUN.
  - RUN: exactly n cycles.
    - Multiply: shift-add, 1 bit/cycle, 2n-bit product.
    - Divide: restoring, 1 quotient bit/cycle.
    - Counter 0..n-1; leave after count n-1.
  - FIX: 1 cycle. Apply signs: product negated if sign(a)^sign(b); quotient sign = sign(a)^sign(b); remainder sign = sign(a). Write HI/LO.
    - MULT/MULTU: HI = product[2n-1:n], LO = product[n-1:0].
    - DIV/DIVU: LO = quotient, HI = remainder.
  - DONE: out_valid=1, result = LO, zero = (LO==0). Returns to IDLE next cycle.
- in_ready=0 in RUN, FIX and DONE.
- Latency: accept at edge t, out_valid high during the cycle after edge t+n+2, i.e. n+2 cycles after the accept edge. in_ready returns high the cycle after DONE.
- Divide by zero is detected at accept. RUN is skipped and the FSM goes to FIX, then DONE. HI = a, LO = all ones, div_by_zero=1.
- Signed overflow: DIV of most-negative by −1 gives LO = most-negative, HI = 0. Not flagged.
- MULTU/DIVU treat operands as unsigned. Sign fix-up is skipped.
- in_valid while in_ready=0 is ignored. The requester must hold it; the block does not queue.
- HI/LO are unchanged by every op except MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Reset, any state including mid-RUN:
  - Aborts the operation.
  - FSM=IDLE, HI=LO=0, result=0, zero=1, out_valid=0, div_by_zero=0.
  - in_ready=1 in the cycle after the reset edge.
  - The aborted operation produces no out_valid.
- rst has priority over a simultaneous accept.

Test Plan:
- n=32, ADD a=0xFFFFFFFF b=1 → out_valid next cycle, result=0, zero=1. Then SUB a=5 b=7 back-to-back → result=0xFFFFFFFE, zero=0.
- SLT a=0xFFFFFFFF b=1 → result=1. SLTU with the same operands → result=0.
- MULT a=−3 (0xFFFFFFFD) b=7 → in_ready low for 34 cycles, out_valid at accept+34, result=0xFFFFFFEB, then MFHI → 0xFFFFFFFF. MULTU 0xFFFFFFFF×2 → HI=1, LO=0xFFFFFFFE, zero=0.
- DIV a=−7 b=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU 100/7 → LO=14, HI=2.
- DIVU a=9 b=0 → out_valid at accept+2, div_by_zero=1, result=0xFFFFFFFF, MFHI → 9. A following ADD clears div_by_zero.
- Start MULT 1000×1000, assert rst at RUN cycle 10 → no out_valid, in_ready=1 next cycle, MFLO → 0. in_valid held during busy is not double-accepted.

Source files
------------

// File: rtl/alu_seq.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops plus iterative
// multiply/divide into internal HI/LO registers behind a valid/ready handshake.
module alu_seq #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         out_valid,
    output logic [n-1:0] result,
    output logic         zero,
    output logic         div_by_zero
);
    localparam int CW = $clog2(n);

    localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_NOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011, OP_SUB  = 4'b0100, OP_MFHI = 4'b0101;
    localparam logic [3:0] OP_MFLO = 4'b0110, OP_SLT  = 4'b0111, OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MULT = 4'b1001, OP_MULTU = 4'b1010, OP_DIV = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100, OP_XOR  = 4'b1101, OP_MTHI = 4'b1110;
    localparam logic [3:0] OP_MTLO = 4'b1111;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
    logic          is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, dz_q, dz_d;
    logic [n-1:0]  hi_q, hi_d, lo_q, lo_d, result_q, result_d;
    logic          out_valid_q, out_valid_d, zero_q, zero_d, dbz_q, dbz_d;

    logic          accept, is_long, is_div_op, signed_op, sa, sb;
    logic [n-1:0]  mag_a, mag_b, alu_res;
    logic [n:0]    mul_sum, div_rs;
    logic [n-1:0]  div_diff;
    logic          div_borrow;
    logic [2*n-1:0] prod_raw, prod_fix;

    assign in_ready    = (state_q == IDLE);
    assign accept      = in_valid && in_ready;
    assign is_long     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign is_div_op   = (op == OP_DIV) || (op == OP_DIVU);
    assign signed_op   = (op == OP_MULT) || (op == OP_DIV);
    assign sa          = signed_op && a[n-1];
    assign sb          = signed_op && b[n-1];
    assign mag_a       = sa ? -a : a;
    assign mag_b       = sb ? -b : b;

    // Multiply: {acc_hi, acc_lo} holds partial product over remaining multiplier bits.
    assign mul_sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    assign div_rs      = {acc_hi_q, acc_lo_q[n-1]};
    assign div_borrow  = div_rs < {1'b0, opnd_q};
    assign div_diff    = div_rs[n-1:0] - opnd_q;
    assign prod_raw    = {acc_hi_q, acc_lo_q};
    assign prod_fix    = neg_lo_q ? -prod_raw : prod_raw;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOR:  alu_res = ~(a | b);
            OP_XOR:  alu_res = a ^ b;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLT:  alu_res = {{(n-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {{(n-1){1'b0}}, a < b};
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            OP_MTHI, OP_MTLO: alu_res = a;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        opnd_d      = opnd_q;
        is_div_d    = is_div_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        dz_d        = dz_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: if (accept) begin
                if (is_long) begin
                    cnt_d    = '0;
                    is_div_d = is_div_op;
                    neg_lo_d = sa ^ sb;
                    neg_hi_d = sa;
                    acc_hi_d = '0;
                    if (is_div_op && b == '0) begin
                        dz_d     = 1'b1;
                        acc_hi_d = a;
                        acc_lo_d = '1;
                        state_d  = FIX;
                    end else begin
                        dz_d     = 1'b0;
                        opnd_d   = is_div_op ? mag_b : mag_a;
                        acc_lo_d = is_div_op ? mag_a : mag_b;
                        state_d  = RUN;
                    end
                end else begin
                    out_valid_d = 1'b1;
                    result_d    = alu_res;
                    zero_d      = (alu_res == '0);
                    dbz_d       = 1'b0;
                    if (op == OP_MTHI) hi_d = a;
                    if (op == OP_MTLO) lo_d = a;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    acc_hi_d = div_borrow ? div_rs[n-1:0] : div_diff;
                    acc_lo_d = {acc_lo_q[n-2:0], ~div_borrow};
                end else begin
                    acc_hi_d = mul_sum[n:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[n-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(n-1)) state_d = FIX;
            end
            FIX: begin
                if (dz_q) begin
                    hi_d = acc_hi_q;
                    lo_d = acc_lo_q;
                end else if (is_div_q) begin
                    lo_d = neg_lo_q ? -acc_lo_q : acc_lo_q;
                    hi_d = neg_hi_q ? -acc_hi_q : acc_hi_q;
                end else begin
                    hi_d = prod_fix[2*n-1:n];
                    lo_d = prod_fix[n-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                out_valid_d = 1'b1;
                result_d    = lo_q;
                zero_d      = (lo_q == '0);
                dbz_d       = dz_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opnd_q      <= '0;
            is_div_q    <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            dz_q        <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            opnd_q      <= opnd_d;
            is_div_q    <= is_div_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            dz_q        <= dz_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;
endmodule
